// File: rtl/pipe_execute_stage.sv
// Y86 pipelined execute stage: ALU, condition evaluation, CC register and E/M pipeline register.
// Optional IADDQ_EN macro adds the iaddq instruction (icode C, valE = valB + valC).
module pipe_execute_stage #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_stall,
    input  logic             m_bubble,
    input  logic             cc_block,
    input  logic [2:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_cnd,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic [2:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    localparam int         MSB     = WIDTH - 1;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
`ifdef IADDQ_EN
    localparam logic [3:0] IIADDQ  = 4'hC;
`endif
    localparam logic [2:0]       SAOK       = 3'd1;
    localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

    logic [WIDTH-1:0] aluOut;
    logic             aluOvf;
    logic             flagsValid;
    logic             flagZf;
    logic             flagSf;
    logic             condTrue;
    logic             ccWrite;

    logic ccZf_q, ccSf_q, ccOf_q;
    logic ccZf_d, ccSf_d, ccOf_d;

    logic [2:0]       mStat_q,  mStat_d;
    logic [3:0]       mIcode_q, mIcode_d;
    logic             mCnd_q,   mCnd_d;
    logic [WIDTH-1:0] mValE_q,  mValE_d;
    logic [WIDTH-1:0] mValA_q,  mValA_d;
    logic [3:0]       mDstE_q,  mDstE_d;
    logic [3:0]       mDstM_q,  mDstM_d;

    // flagsValid marks the results that are allowed to set the condition codes.
    always_comb begin
        aluOut     = '0;
        aluOvf     = 1'b0;
        flagsValid = 1'b0;
        case (E_icode)
            IRRMOVQ:          aluOut = E_valA;
            IIRMOVQ:          aluOut = E_valC;
            IRMMOVQ, IMRMOVQ: aluOut = E_valB + E_valC;
            IPUSHQ, ICALL:    aluOut = E_valB - STACK_STEP;
            IPOPQ, IRET:      aluOut = E_valB + STACK_STEP;
            IOPQ: begin
                flagsValid = 1'b1;
                case (E_ifun)
                    4'h0: begin
                        aluOut = E_valB + E_valA;
                        aluOvf = (E_valA[MSB] == E_valB[MSB]) && (aluOut[MSB] != E_valA[MSB]);
                    end
                    4'h1: begin
                        aluOut = E_valB - E_valA;
                        aluOvf = (E_valB[MSB] != E_valA[MSB]) && (aluOut[MSB] != E_valB[MSB]);
                    end
                    4'h2:    aluOut = E_valB & E_valA;
                    4'h3:    aluOut = E_valB ^ E_valA;
                    default: flagsValid = 1'b0;
                endcase
            end
`ifdef IADDQ_EN
            IIADDQ: begin
                flagsValid = 1'b1;
                aluOut     = E_valB + E_valC;
                aluOvf     = (E_valC[MSB] == E_valB[MSB]) && (aluOut[MSB] != E_valB[MSB]);
            end
`endif
            default: aluOut = '0;
        endcase
    end

    assign flagZf = (aluOut == '0);
    assign flagSf = aluOut[MSB];

    // Conditions look at the registered CC, never at this cycle's ALU flags.
    always_comb begin
        condTrue = 1'b0;
        case (E_ifun)
            4'h0:    condTrue = 1'b1;
            4'h1:    condTrue = (ccSf_q ^ ccOf_q) | ccZf_q;
            4'h2:    condTrue = ccSf_q ^ ccOf_q;
            4'h3:    condTrue = ccZf_q;
            4'h4:    condTrue = ~ccZf_q;
            4'h5:    condTrue = ~(ccSf_q ^ ccOf_q);
            4'h6:    condTrue = ~(ccSf_q ^ ccOf_q) & ~ccZf_q;
            default: condTrue = 1'b0;
        endcase
    end

    assign e_cnd  = ((E_icode == IRRMOVQ) || (E_icode == IJXX)) && condTrue;
    assign e_dstE = ((E_icode == IRRMOVQ) && !e_cnd) ? RNONE : E_dstE;
    assign e_valE = aluOut;

    assign ccWrite = flagsValid && (E_stat == SAOK) && !cc_block && !m_stall;

    always_comb begin
        ccZf_d = ccZf_q;
        ccSf_d = ccSf_q;
        ccOf_d = ccOf_q;
        if (ccWrite) begin
            ccZf_d = flagZf;
            ccSf_d = flagSf;
            ccOf_d = aluOvf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ccZf_q <= 1'b1;
            ccSf_q <= 1'b0;
            ccOf_q <= 1'b0;
        end else begin
            ccZf_q <= ccZf_d;
            ccSf_q <= ccSf_d;
            ccOf_q <= ccOf_d;
        end
    end

    // A bubble overrides a stall; a bubble is the same NOP image that reset loads.
    always_comb begin
        mStat_d  = E_stat;
        mIcode_d = E_icode;
        mCnd_d   = e_cnd;
        mValE_d  = e_valE;
        mValA_d  = E_valA;
        mDstE_d  = e_dstE;
        mDstM_d  = E_dstM;
        if (m_bubble) begin
            mStat_d  = SAOK;
            mIcode_d = INOP;
            mCnd_d   = 1'b0;
            mValE_d  = '0;
            mValA_d  = '0;
            mDstE_d  = RNONE;
            mDstM_d  = RNONE;
        end else if (m_stall) begin
            mStat_d  = mStat_q;
            mIcode_d = mIcode_q;
            mCnd_d   = mCnd_q;
            mValE_d  = mValE_q;
            mValA_d  = mValA_q;
            mDstE_d  = mDstE_q;
            mDstM_d  = mDstM_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mStat_q  <= SAOK;
            mIcode_q <= INOP;
            mCnd_q   <= 1'b0;
            mValE_q  <= '0;
            mValA_q  <= '0;
            mDstE_q  <= RNONE;
            mDstM_q  <= RNONE;
        end else begin
            mStat_q  <= mStat_d;
            mIcode_q <= mIcode_d;
            mCnd_q   <= mCnd_d;
            mValE_q  <= mValE_d;
            mValA_q  <= mValA_d;
            mDstE_q  <= mDstE_d;
            mDstM_q  <= mDstM_d;
        end
    end

    assign cc_zf   = ccZf_q;
    assign cc_sf   = ccSf_q;
    assign cc_of   = ccOf_q;
    assign M_stat  = mStat_q;
    assign M_icode = mIcode_q;
    assign M_cnd   = mCnd_q;
    assign M_valE  = mValE_q;
    assign M_valA  = mValA_q;
    assign M_dstE  = mDstE_q;
    assign M_dstM  = mDstM_q;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Self-checking bench for pipe_execute_stage: vector table with an E/M scoreboard on a 64-bit
// instance, plus a hand-written sequence on a 32-bit instance. Honours IADDQ_EN when defined.
module tb_pipe_execute_stage;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;
`ifdef IADDQ_EN
    localparam logic [2:0]  IADDQ_CC  = 3'b100;
    localparam logic        IADDQ_CND = 1'b1;
`else
    localparam logic [2:0]  IADDQ_CC  = 3'b000;
    localparam logic        IADDQ_CND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mStall, mBubble, ccBlock;
    logic [2:0]  eStat;
    logic [3:0]  eIcode, eIfun, eDstEIn, eDstMIn;
    logic [63:0] eValA, eValB, eValC;
    logic [63:0] eValE, mValE, mValA;
    logic [3:0]  eDstE, mIcode, mDstE, mDstM;
    logic        eCnd, ccZf, ccSf, ccOf, mCnd;
    logic [2:0]  mStat;

    logic        r32, stall32, bubble32, block32;
    logic [2:0]  stat32;
    logic [3:0]  icode32, ifun32, dstEIn32, dstMIn32;
    logic [31:0] valA32, valB32, valC32;
    logic [31:0] eValE32, mValE32, mValA32;
    logic [3:0]  eDstE32, mIcode32, mDstE32, mDstM32;
    logic        eCnd32, zf32, sf32, of32, mCnd32;
    logic [2:0]  mStat32;

    pipe_execute_stage #(.WIDTH(64), .RNONE(4'hF)) dut (
        .clk(clk), .reset(reset), .m_stall(mStall), .m_bubble(mBubble), .cc_block(ccBlock),
        .E_stat(eStat), .E_icode(eIcode), .E_ifun(eIfun), .E_valA(eValA), .E_valB(eValB),
        .E_valC(eValC), .E_dstE(eDstEIn), .E_dstM(eDstMIn),
        .e_valE(eValE), .e_dstE(eDstE), .e_cnd(eCnd),
        .cc_zf(ccZf), .cc_sf(ccSf), .cc_of(ccOf),
        .M_stat(mStat), .M_icode(mIcode), .M_cnd(mCnd), .M_valE(mValE), .M_valA(mValA),
        .M_dstE(mDstE), .M_dstM(mDstM)
    );

    pipe_execute_stage #(.WIDTH(32), .RNONE(4'hF)) dut32 (
        .clk(clk), .reset(r32), .m_stall(stall32), .m_bubble(bubble32), .cc_block(block32),
        .E_stat(stat32), .E_icode(icode32), .E_ifun(ifun32), .E_valA(valA32), .E_valB(valB32),
        .E_valC(valC32), .E_dstE(dstEIn32), .E_dstM(dstMIn32),
        .e_valE(eValE32), .e_dstE(eDstE32), .e_cnd(eCnd32),
        .cc_zf(zf32), .cc_sf(sf32), .cc_of(of32),
        .M_stat(mStat32), .M_icode(mIcode32), .M_cnd(mCnd32), .M_valE(mValE32), .M_valA(mValA32),
        .M_dstE(mDstE32), .M_dstM(mDstM32)
    );

    typedef struct {
        logic        rst, stall, bubble, block;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valA, valB, valC;
        logic [3:0]  dstE, dstM;
        logic [63:0] expValE;
        logic [3:0]  expDstE;
        logic        expCnd;
        logic [2:0]  expCC;
        logic [2:0]  expMStat;
        logic [3:0]  expMIcode;
        logic        expMCnd;
        logic [63:0] expMValE, expMValA;
        logic [3:0]  expMDstE, expMDstM;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  cc;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE, valA;
        logic [3:0]  dstE, dstM;
    } mExp_t;

    localparam int NVEC = 30;
    vec_t  vecs [NVEC];
    mExp_t sb [$];
    int    checks = 0;
    int    errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        mExp_t e;
        mExp_t got;
        @(negedge clk);
        reset   = v.rst;    mStall  = v.stall;  mBubble = v.bubble; ccBlock = v.block;
        eStat   = v.stat;   eIcode  = v.icode;  eIfun   = v.ifun;
        eValA   = v.valA;   eValB   = v.valB;   eValC   = v.valC;
        eDstEIn = v.dstE;   eDstMIn = v.dstM;
        #1;
        checkOutput($sformatf("v%0d e_valE", idx), eValE, v.expValE);
        checkOutput($sformatf("v%0d e_dstE", idx), 64'(eDstE), 64'(v.expDstE));
        checkOutput($sformatf("v%0d e_cnd", idx), 64'(eCnd), 64'(v.expCnd));
        e.idx = idx;          e.cc = v.expCC;         e.stat = v.expMStat;
        e.icode = v.expMIcode; e.cnd = v.expMCnd;     e.valE = v.expMValE;
        e.valA = v.expMValA;  e.dstE = v.expMDstE;    e.dstM = v.expMDstM;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL v%0d scoreboard empty actual=0 expected=1", idx);
        end else begin
            got = sb.pop_front();
            checkOutput($sformatf("v%0d cc", got.idx), 64'({ccZf, ccSf, ccOf}), 64'(got.cc));
            checkOutput($sformatf("v%0d M_stat", got.idx), 64'(mStat), 64'(got.stat));
            checkOutput($sformatf("v%0d M_icode", got.idx), 64'(mIcode), 64'(got.icode));
            checkOutput($sformatf("v%0d M_cnd", got.idx), 64'(mCnd), 64'(got.cnd));
            checkOutput($sformatf("v%0d M_valE", got.idx), mValE, got.valE);
            checkOutput($sformatf("v%0d M_valA", got.idx), mValA, got.valA);
            checkOutput($sformatf("v%0d M_dstE", got.idx), 64'(mDstE), 64'(got.dstE));
            checkOutput($sformatf("v%0d M_dstM", got.idx), 64'(mDstM), 64'(got.dstM));
        end
    endtask

    // Drives one E-stage instruction into the 32-bit instance and returns after the next edge.
    task automatic drive32(input logic rst, input logic [3:0] icode, input logic [3:0] ifun,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] dE);
        @(negedge clk);
        r32 = rst; stall32 = 1'b0; bubble32 = 1'b0; block32 = 1'b0; stat32 = 3'd1;
        icode32 = icode; ifun32 = ifun; valA32 = a; valB32 = b; valC32 = 32'h0;
        dstEIn32 = dE; dstMIn32 = 4'hF;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=expired expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //            rst  stl  bub  blk  stat icode ifun valA          valB          valC          dE    dM   | eValE         eDstE eCnd | CC      mStat mIcode mCnd mValE       mValA        mDstE mDstM
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,3'd1,4'h6,4'h0,64'h1,        MAXP,         64'h0,        4'h2,4'hF, MINN,         4'h2,1'b0, 3'b100, 3'd1,4'h1,1'b0,64'h0,      64'h0,       4'hF,4'hF};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h6,4'h0,64'h1,        MAXP,         64'h0,        4'h2,4'hF, MINN,         4'h2,1'b0, 3'b011, 3'd1,4'h6,1'b0,MINN,       64'h1,       4'h2,4'hF};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h6,4'h1,64'h5,        64'h5,        64'h0,        4'h4,4'hF, 64'h0,        4'h4,1'b0, 3'b100, 3'd1,4'h6,1'b0,64'h0,      64'h5,       4'h4,4'hF};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h2,4'h4,64'h1234,     64'h0,        64'h0,        4'h3,4'hF, 64'h1234,     4'hF,1'b0, 3'b100, 3'd1,4'h2,1'b0,64'h1234,   64'h1234,    4'hF,4'hF};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h2,4'h3,64'h55,       64'h0,        64'h0,        4'h3,4'hF, 64'h55,       4'h3,1'b1, 3'b100, 3'd1,4'h2,1'b1,64'h55,     64'h55,      4'h3,4'hF};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,3'd1,4'h6,4'h3,64'hF0,       64'h0F,       64'h0,        4'h5,4'hF, 64'hFF,       4'h5,1'b0, 3'b100, 3'd1,4'h6,1'b0,64'hFF,     64'hF0,      4'h5,4'hF};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h6,4'h3,64'hF0,       64'h0F,       64'h0,        4'h5,4'hF, 64'hFF,       4'h5,1'b0, 3'b000, 3'd1,4'h6,1'b0,64'hFF,     64'hF0,      4'h5,4'hF};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h7,4'h2,64'h40,       64'h0,        64'h0,        4'hF,4'hF, 64'h0,        4'hF,1'b0, 3'b000, 3'd1,4'h7,1'b0,64'h0,      64'h40,      4'hF,4'hF};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h6,4'h1,64'h1,        MINN,         64'h0,        4'h6,4'hF, MAXP,         4'h6,1'b0, 3'b001, 3'd1,4'h6,1'b0,MAXP,       64'h1,       4'h6,4'hF};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h7,4'h2,64'h80,       64'h0,        64'h0,        4'hF,4'hF, 64'h0,        4'hF,1'b1, 3'b001, 3'd1,4'h7,1'b1,64'h0,      64'h80,      4'hF,4'hF};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h7,4'h1,64'h81,       64'h0,        64'h0,        4'hF,4'hF, 64'h0,        4'hF,1'b1, 3'b001, 3'd1,4'h7,1'b1,64'h0,      64'h81,      4'hF,4'hF};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h2,4'h6,64'h77,       64'h0,        64'h0,        4'h7,4'hF, 64'h77,       4'hF,1'b0, 3'b001, 3'd1,4'h2,1'b0,64'h77,     64'h77,      4'hF,4'hF};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h2,4'h5,64'h66,       64'h0,        64'h0,        4'h7,4'hF, 64'h66,       4'hF,1'b0, 3'b001, 3'd1,4'h2,1'b0,64'h66,     64'h66,      4'hF,4'hF};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'hA,4'h0,64'h9,        64'h100,      64'h0,        4'h4,4'hF, 64'hF8,       4'h4,1'b0, 3'b001, 3'd1,4'hA,1'b0,64'hF8,     64'h9,       4'h4,4'hF};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,3'd1,4'h6,4'h0,64'h1,        64'h1,        64'h0,        4'h2,4'hF, 64'h2,        4'h2,1'b0, 3'b001, 3'd1,4'hA,1'b0,64'hF8,     64'h9,       4'h4,4'hF};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b0,3'd1,4'h4,4'h0,64'h3,        64'h10,       64'h20,       4'hF,4'hF, 64'h30,       4'hF,1'b0, 3'b001, 3'd1,4'hA,1'b0,64'hF8,     64'h9,       4'h4,4'hF};
        vecs[16] = '{1'b0,1'b1,1'b1,1'b0,3'd1,4'h6,4'h0,64'h0,        64'h0,        64'h0,        4'h2,4'hF, 64'h0,        4'h2,1'b0, 3'b001, 3'd1,4'h1,1'b0,64'h0,      64'h0,       4'hF,4'hF};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h6,4'h5,64'h3,        64'h4,        64'h0,        4'h2,4'hF, 64'h0,        4'h2,1'b0, 3'b001, 3'd1,4'h6,1'b0,64'h0,      64'h3,       4'h2,4'hF};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0,3'd3,4'h6,4'h0,64'h0,        64'h0,        64'h0,        4'h2,4'hF, 64'h0,        4'h2,1'b0, 3'b001, 3'd3,4'h6,1'b0,64'h0,      64'h0,       4'h2,4'hF};
        vecs[19] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h5,4'h0,64'h0,        64'h1000,     64'h8,        4'hF,4'h3, 64'h1008,     4'hF,1'b0, 3'b001, 3'd1,4'h5,1'b0,64'h1008,   64'h0,       4'hF,4'h3};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'hB,4'h0,64'h0,        64'h200,      64'h0,        4'h4,4'h5, 64'h208,      4'h4,1'b0, 3'b001, 3'd1,4'hB,1'b0,64'h208,    64'h0,       4'h4,4'h5};
        vecs[21] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h8,4'h0,64'h0,        64'h200,      64'h400,      4'h4,4'hF, 64'h1F8,      4'h4,1'b0, 3'b001, 3'd1,4'h8,1'b0,64'h1F8,    64'h0,       4'h4,4'hF};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h9,4'h0,64'h0,        64'h1F8,      64'h0,        4'h4,4'hF, 64'h200,      4'h4,1'b0, 3'b001, 3'd1,4'h9,1'b0,64'h200,    64'h0,       4'h4,4'hF};
        vecs[23] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h3,4'h0,64'h0,        64'h0,        64'hABC,      4'h2,4'hF, 64'hABC,      4'h2,1'b0, 3'b001, 3'd1,4'h3,1'b0,64'hABC,    64'h0,       4'h2,4'hF};
        vecs[24] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h2,4'h0,64'h11,       64'h0,        64'h0,        4'h1,4'hF, 64'h11,       4'h1,1'b1, 3'b001, 3'd1,4'h2,1'b1,64'h11,     64'h11,      4'h1,4'hF};
        vecs[25] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h6,4'h2,64'hFF0,      64'h0FF,      64'h0,        4'h2,4'hF, 64'hF0,       4'h2,1'b0, 3'b000, 3'd1,4'h6,1'b0,64'hF0,     64'hFF0,     4'h2,4'hF};
        vecs[26] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'hC,4'h0,64'h0,        NEG3,         64'h3,        4'h2,4'hF, 64'h0,        4'h2,1'b0, IADDQ_CC,3'd1,4'hC,1'b0,64'h0,     64'h0,       4'h2,4'hF};
        vecs[27] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h7,4'h3,64'h0,        64'h0,        64'h0,        4'hF,4'hF, 64'h0,        4'hF,IADDQ_CND, IADDQ_CC,3'd1,4'h7,IADDQ_CND,64'h0,64'h0,   4'hF,4'hF};
        vecs[28] = '{1'b1,1'b0,1'b0,1'b0,3'd1,4'h6,4'h0,64'h1,        64'h1,        64'h0,        4'h2,4'h3, 64'h2,        4'h2,1'b0, 3'b100, 3'd1,4'h1,1'b0,64'h0,      64'h0,       4'hF,4'hF};
        vecs[29] = '{1'b0,1'b0,1'b0,1'b0,3'd1,4'h7,4'h3,64'h0,        64'h0,        64'h0,        4'hF,4'hF, 64'h0,        4'hF,1'b1, 3'b100, 3'd1,4'h7,1'b1,64'h0,      64'h0,       4'hF,4'hF};

        r32 = 1'b1; stall32 = 1'b0; bubble32 = 1'b0; block32 = 1'b0; stat32 = 3'd1;
        icode32 = 4'h1; ifun32 = 4'h0; valA32 = '0; valB32 = '0; valC32 = '0;
        dstEIn32 = 4'hF; dstMIn32 = 4'hF;

        $display("[TB] 64-bit vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] 32-bit sequence");
        drive32(1'b1, 4'h1, 4'h0, 32'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        checkOutput("w32 reset M_icode", 64'(mIcode32), 64'h1);
        checkOutput("w32 reset cc", 64'({zf32, sf32, of32}), 64'b100);

        drive32(1'b0, 4'hB, 4'h0, 32'h0, 32'hFFFF_FFFC, 4'h4);
        checkOutput("w32 popq e_valE", 64'(eValE32), 64'h4);
        @(posedge clk); #1;
        checkOutput("w32 popq M_valE", 64'(mValE32), 64'h4);
        checkOutput("w32 popq M_icode", 64'(mIcode32), 64'hB);

        drive32(1'b0, 4'h6, 4'h0, 32'h1, 32'h7FFF_FFFF, 4'h2);
        checkOutput("w32 addq e_valE", 64'(eValE32), 64'h8000_0000);
        @(posedge clk); #1;
        checkOutput("w32 addq cc", 64'({zf32, sf32, of32}), 64'b011);

        drive32(1'b1, 4'h6, 4'h0, 32'h2, 32'h3, 4'h2);
        checkOutput("w32 rst e_valE", 64'(eValE32), 64'h5);
        @(posedge clk); #1;
        checkOutput("w32 rst M_icode", 64'(mIcode32), 64'h1);
        checkOutput("w32 rst M_dstE", 64'(mDstE32), 64'hF);
        checkOutput("w32 rst M_valE", 64'(mValE32), 64'h0);
        checkOutput("w32 rst M_stat", 64'(mStat32), 64'h1);
        checkOutput("w32 rst cc", 64'({zf32, sf32, of32}), 64'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_execute_stage.md
Name: pipe_execute_stage

Overview:
- Parametrised execute stage of the pipelined Y86 processor. It sits between the D/E and E/M pipeline registers.
- Combinationally computes ALU result, branch/cmov condition and forwarded dstE from the E-register fields.
- Owns the condition-code register (ZF/SF/OF).
- Owns the E/M pipeline register, with stall/bubble control from the pipeline control unit.

Parameters:
WIDTH, 64, datapath width in bits for valA/valB/valC/valE; minimum 8.
RNONE, 4'hF, register ID meaning "no destination".

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
m_stall  input  1  hold E/M register contents
m_bubble  input  1  load NOP bubble into E/M register
cc_block  input  1  suppress CC update (exception in M/W)
E_stat  input  3  stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
E_icode  input  4  instruction code
E_ifun  input  4  function code
E_valA  input  WIDTH  operand A / data to store
E_valB  input  WIDTH  operand B / stack pointer
E_valC  input  WIDTH  immediate/displacement
E_dstE  input  4  ALU destination register
E_dstM  input  4  memory destination register
e_valE  output  WIDTH  combinational ALU result (forwarding)
e_dstE  output  4  combinational dstE after cmov squash (forwarding)
e_cnd  output  1  combinational condition result
cc_zf, cc_sf, cc_of  output  1 each  registered condition codes
M_stat  output  3  registered E_stat
M_icode  output  4  registered E_icode
M_cnd  output  1  registered e_cnd
M_valE  output  WIDTH  registered e_valE
M_valA  output  WIDTH  registered E_valA
M_dstE  output  4  registered e_dstE
M_dstM  output  4  registered E_dstM

Behaviour:
- Single clock clk. Reset is synchronous and active-high on port reset. All state changes on the rising edge only.
- ALU selection by icode. All arithmetic is modulo 2^WIDTH.
  - OPq (6): valE = valB op valA. ifun 0 add, 1 sub (valB-valA), 2 and, 3 xor. ifun 4..15 gives valE=0 and no CC update.
  - rrmovq/cmovXX (2): valE = valA.
  - irmovq (3): valE = valC.
  - rmmovq (4), mrmovq (5): valE = valB+valC.
  - pushq (A), call (8): valE = valB-8.
  - popq (B), ret (9): valE = valB+8.
  - All other icodes: valE = 0.
- Flags computed from the OPq result:
  - ZF = (valE==0).
  - SF = valE[MSB].
  - OF for add: operand signs equal and result sign differs.
  - OF for sub: sign(valB) != sign(valA) and sign(result) != sign(valB).
  - OF for and/xor: 0.
- Condition e_cnd, evaluated from registered cc_* (not the same-cycle result):
  - ifun 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~(SF^OF).
  - 6 g: ~(SF^OF)&~ZF.
  - 7..15: 0.
  - e_cnd is meaningful for icode 2 and 7; it is 0 for all other icodes.
- e_dstE = RNONE when icode==2 and e_cnd==0; otherwise E_dstE.
- CC update at clock edge: when E_icode==6, ifun<=3, E_stat==AOK, cc_block==0, m_stall==0 and reset==0.
  - CC then takes the flags of the current result.
  - Otherwise CC holds.
- E/M register priority: reset > m_bubble > m_stall > load.
  - Bubble/reset value: M_icode=1 (nop), M_stat=1, M_dstE=M_dstM=RNONE, M_cnd=0, M_valE=M_valA=0.
  - m_stall and m_bubble together: bubble wins.
- CC reset value: ZF=1, SF=0, OF=0.
- Latency: e_* are combinational (0 cycles); M_* and cc_* update 1 cycle after inputs.
- A back-to-back OPq followed by a cmov/jXX sees the updated CC in the next cycle (no internal bypass).
- Reset mid-stream discards the E/M contents and the CC in the same edge.

Optional Feature:
- Macro IADDQ_EN.
- Defined: icode C (iaddq) gives valE = valB+valC. Flags and OF are computed as for add, and CC updates under the same gating rules as OPq.
- Undefined: icode C is treated as unknown (valE=0, no CC update, e_cnd=0).

Test Plan:
- Case 1: reset, then WIDTH=64 OPq add with valA=1, valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0x8000_0000_0000_0000; after edge cc_sf=1, cc_of=1, cc_zf=0, M_valE equals e_valE, M_icode=6.
- Case 2: subq valA=valB=5 -> ZF=1. Next cycle cmovne (ifun 4) with E_dstE=3 -> e_cnd=0, e_dstE=F, M_dstE=F. Repeating with cmove (ifun 3) -> M_dstE=3.
- Case 3: cc_block=1 during xorq giving a nonzero result -> CC unchanged (ZF stays 1). With cc_block=0 -> ZF=0, OF=0.
- Case 4: load pushq valB=0x100. Assert m_stall for 2 cycles with different E inputs -> M_valE stays 0xF8. Then m_bubble (with stall also high) -> M_icode=1, M_dstE=F, M_stat=1.
- Case 5: WIDTH=32, popq valB=0xFFFF_FFFC -> e_valE=0x0000_0004 (wraps). Then assert reset during a valid addq -> M_* take bubble values and CC = ZF1/SF0/OF0 next edge.
- Case 6 (IADDQ_EN defined): iaddq valB=-3, valC=3 -> valE=0, ZF=1. With IADDQ_EN undefined -> valE=0 but CC unchanged.
